// File: rtl/jesd_ctrl_char_cgs.sv
// ---------------------------------------------------------------------------
// jesd_ctrl_char_cgs
//
// Purpose: per-octet 8b/10b control-character classifier plus one code-group
// synchronisation (CGS) state machine per receive lane.
//
// Optional feature: define JESD_CTRL_CHAR_STATS_EN to add stat_af_cnt, a
// per-lane saturating count of /A/ and /F/ octets seen while in DATA or CHECK.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   data_in      decoded octets, lane L octet n at [(L*OCTETS+n)*8 +: 8]
//   is_k         control flag per octet
//   code_err     not-in-table / disparity error per octet
//   valid_in     qualifies data_in, is_k, code_err
//   kcls_out     registered 3-bit class per octet
//   valid_out    valid_in delayed one cycle
//   lane_state   per-lane CGS state (0 INIT, 1 CHECK, 2 DATA); also the
//                debug view of every lane FSM
//   sync_n       registered, low while any lane is in INIT
//   stat_af_cnt  (JESD_CTRL_CHAR_STATS_EN only) 16 bits per lane
//
// Handshake: there is no back-pressure. A word is consumed on every rising
// edge where valid_in=1; with valid_in=0 the lane FSMs hold, the classifier
// still runs, and valid_out follows one cycle later.
// ---------------------------------------------------------------------------
module jesd_ctrl_char_cgs #(
  parameter int LANES      = 2,
  parameter int OCTETS     = 2,
  parameter int K_THRESH   = 4,
  parameter int ERR_THRESH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*OCTETS*8-1:0]   data_in,
  input  logic [LANES*OCTETS-1:0]     is_k,
  input  logic [LANES*OCTETS-1:0]     code_err,
  input  logic                        valid_in,
  output logic [LANES*OCTETS*3-1:0]   kcls_out,
  output logic                        valid_out,
  output logic [LANES*2-1:0]          lane_state,
  output logic                        sync_n
`ifdef JESD_CTRL_CHAR_STATS_EN
  ,
  output logic [LANES*16-1:0]         stat_af_cnt
`endif
);

  localparam int NOCT = LANES * OCTETS;
  localparam logic [3:0] K_TH   = 4'(K_THRESH);
  localparam logic [3:0] ERR_TH = 4'(ERR_THRESH);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DATA  = 2'd2
  } cgs_state_t;

  typedef struct packed {
    cgs_state_t state;
    logic [3:0] k_cnt;
    logic [2:0] err_cnt;
    logic [2:0] good_cnt;
  } lane_ctx_t;

  // Octet class: 0 data, 1 K28.5, 2 K28.0, 3 K28.3, 4 K28.4, 5 K28.7,
  // 6 other legal K, 7 illegal K.
  function automatic logic [2:0] classify(input logic [7:0] d, input logic k);
    logic [2:0] cls;
    cls = 3'd0;
    if (k) begin
      case (d)
        8'hBC:   cls = 3'd1;
        8'h1C:   cls = 3'd2;
        8'h7C:   cls = 3'd3;
        8'h9C:   cls = 3'd4;
        8'hFC:   cls = 3'd5;
        8'h3C, 8'h5C, 8'hDC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE:
                 cls = 3'd6;
        default: cls = 3'd7;
      endcase
    end
    return cls;
  endfunction

  // Advance one lane context by exactly one octet.
  function automatic lane_ctx_t step_octet(input lane_ctx_t c,
                                           input logic [2:0] cls,
                                           input logic cerr);
    lane_ctx_t n;
    logic      bad;
    n   = c;
    bad = cerr || (cls == 3'd7);
    case (c.state)
      ST_INIT: begin
        if ((cls == 3'd1) && !cerr) begin
          if ((c.k_cnt + 4'd1) >= K_TH) begin
            n.state = ST_DATA;
            n.k_cnt = 4'd0;
          end else begin
            n.k_cnt = c.k_cnt + 4'd1;
          end
        end else begin
          n.k_cnt = 4'd0;
        end
      end
      ST_DATA: begin
        if (bad) begin
          n.state    = ST_CHECK;
          n.err_cnt  = 3'd1;
          n.good_cnt = 3'd0;
        end
      end
      ST_CHECK: begin
        if (bad) begin
          if (({1'b0, c.err_cnt} + 4'd1) >= ERR_TH) begin
            n = '0;  // back to INIT with every counter cleared
          end else begin
            n.err_cnt  = c.err_cnt + 3'd1;
            n.good_cnt = 3'd0;
          end
        end else if (c.good_cnt == 3'd3) begin
          // fourth good octet forgives one error
          n.good_cnt = 3'd0;
          n.err_cnt  = c.err_cnt - 3'd1;
          if (c.err_cnt == 3'd1) n.state = ST_DATA;
        end else begin
          n.good_cnt = c.good_cnt + 3'd1;
        end
      end
      default: n = '0;
    endcase
    return n;
  endfunction

  logic [NOCT*3-1:0] kcls_c;
  lane_ctx_t         ctx_q [LANES];
  lane_ctx_t         ctx_d [LANES];
  lane_ctx_t         lane_c;
  logic [2:0]        cls_v;
  logic              sync_d;
`ifdef JESD_CTRL_CHAR_STATS_EN
  logic [15:0]       af_q [LANES];
  logic [15:0]       af_d [LANES];
`endif

  always_comb begin
    kcls_c = '0;
    for (int i = 0; i < NOCT; i++) begin
      kcls_c[i*3 +: 3] = classify(data_in[i*8 +: 8], is_k[i]);
    end
  end

  // Next-state: octets of a word are applied in order, so a transition taken
  // at octet n already governs octet n+1 of the same word.
  always_comb begin
    lane_c = '0;
    cls_v  = '0;
    for (int l = 0; l < LANES; l++) begin
      ctx_d[l] = ctx_q[l];
`ifdef JESD_CTRL_CHAR_STATS_EN
      af_d[l]  = af_q[l];
`endif
    end
    if (valid_in) begin
      for (int l = 0; l < LANES; l++) begin
        lane_c = ctx_q[l];
        for (int n = 0; n < OCTETS; n++) begin
          cls_v = kcls_c[(l*OCTETS+n)*3 +: 3];
`ifdef JESD_CTRL_CHAR_STATS_EN
          if ((lane_c.state != ST_INIT) && ((cls_v == 3'd3) || (cls_v == 3'd5))
              && (af_d[l] != 16'hFFFF)) begin
            af_d[l] = af_d[l] + 16'd1;
          end
`endif
          lane_c = step_octet(lane_c, cls_v, code_err[l*OCTETS+n]);
        end
        ctx_d[l] = lane_c;
      end
    end
    sync_d = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      if (ctx_d[l].state == ST_INIT) sync_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        ctx_q[l] <= '0;
`ifdef JESD_CTRL_CHAR_STATS_EN
        af_q[l]  <= '0;
`endif
      end
      kcls_out  <= '0;
      valid_out <= 1'b0;
      sync_n    <= 1'b0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        ctx_q[l] <= ctx_d[l];
`ifdef JESD_CTRL_CHAR_STATS_EN
        af_q[l]  <= af_d[l];
`endif
      end
      kcls_out  <= kcls_c;
      valid_out <= valid_in;
      sync_n    <= sync_d;
    end
  end

  always_comb begin
    lane_state = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_state[l*2 +: 2] = ctx_q[l].state;
    end
  end

`ifdef JESD_CTRL_CHAR_STATS_EN
  always_comb begin
    stat_af_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      stat_af_cnt[l*16 +: 16] = af_q[l];
    end
  end
`endif

endmodule

// File: tb/tb_jesd_ctrl_char_cgs.sv
// ---------------------------------------------------------------------------
// tb_jesd_ctrl_char_cgs: self-checking bench for jesd_ctrl_char_cgs
// (LANES=2, OCTETS=2, K_THRESH=4, ERR_THRESH=3).
// ---------------------------------------------------------------------------
module tb_jesd_ctrl_char_cgs;
  localparam int LANES      = 2;
  localparam int OCTETS     = 2;
  localparam int K_THRESH   = 4;
  localparam int ERR_THRESH = 3;
  localparam int NOCT       = LANES * OCTETS;

  // octet kinds for the hand-written sequences
  localparam int OK_K = 0;  // K28.5, clean
  localparam int OK_D = 1;  // data 8'h00
  localparam int OK_E = 2;  // K28.5 with code error

  logic                    clk;
  logic                    rst;
  logic [NOCT*8-1:0]       data_in;
  logic [NOCT-1:0]         is_k;
  logic [NOCT-1:0]         code_err;
  logic                    valid_in;
  logic [NOCT*3-1:0]       kcls_out;
  logic                    valid_out;
  logic [LANES*2-1:0]      lane_state;
  logic                    sync_n;
`ifdef JESD_CTRL_CHAR_STATS_EN
  logic [LANES*16-1:0]     stat_af_cnt;
`endif

  jesd_ctrl_char_cgs #(
    .LANES(LANES), .OCTETS(OCTETS), .K_THRESH(K_THRESH), .ERR_THRESH(ERR_THRESH)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .is_k(is_k), .code_err(code_err),
    .valid_in(valid_in), .kcls_out(kcls_out), .valid_out(valid_out),
    .lane_state(lane_state), .sync_n(sync_n)
`ifdef JESD_CTRL_CHAR_STATS_EN
    , .stat_af_cnt(stat_af_cnt)
`endif
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // reference model: plain integers following the CGS rules
  int m_st [LANES];  // 0 INIT, 1 CHECK, 2 DATA
  int m_k  [LANES];
  int m_e  [LANES];
  int m_g  [LANES];
  int m_af [LANES];
  logic [NOCT*3-1:0] m_kcls;
  logic              m_vout;
  logic              m_sync;

  // pending word
  logic [NOCT*8-1:0] td;
  logic [NOCT-1:0]   tk;
  logic [NOCT-1:0]   te;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // K codes: D.x.y octet = {y, x}; K28.y are the comma family.
  function automatic int ref_class(input logic [7:0] d, input logic k);
    int x, y;
    if (!k) return 0;
    x = int'(d[4:0]);
    y = int'(d[7:5]);
    if (x == 28) begin
      case (y)
        0: return 2;
        3: return 3;
        4: return 4;
        5: return 1;
        7: return 5;
        default: return 6;
      endcase
    end
    if (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)) return 6;
    return 7;
  endfunction

  task automatic model_step(input logic v, input logic r);
    int cls, i;
    bit bad;
    if (r) begin
      for (int l = 0; l < LANES; l++) begin
        m_st[l] = 0; m_k[l] = 0; m_e[l] = 0; m_g[l] = 0; m_af[l] = 0;
      end
      m_kcls = '0; m_vout = 1'b0; m_sync = 1'b0;
      return;
    end
    for (int j = 0; j < NOCT; j++) m_kcls[j*3 +: 3] = 3'(ref_class(td[j*8 +: 8], tk[j]));
    m_vout = v;
    if (v) begin
      for (int l = 0; l < LANES; l++) begin
        for (int n = 0; n < OCTETS; n++) begin
          i   = l*OCTETS + n;
          cls = ref_class(td[i*8 +: 8], tk[i]);
          bad = te[i] || cls == 7;
          if (m_st[l] != 0 && (cls == 3 || cls == 5) && m_af[l] < 65535) m_af[l]++;
          if (m_st[l] == 0) begin
            if (cls == 1 && !te[i]) begin
              m_k[l]++;
              if (m_k[l] == K_THRESH) begin m_st[l] = 2; m_k[l] = 0; end
            end else m_k[l] = 0;
          end else if (m_st[l] == 2) begin
            if (bad) begin m_st[l] = 1; m_e[l] = 1; m_g[l] = 0; end
          end else begin
            if (bad) begin
              m_e[l]++; m_g[l] = 0;
              if (m_e[l] >= ERR_THRESH) begin m_st[l] = 0; m_e[l] = 0; m_k[l] = 0; end
            end else begin
              m_g[l]++;
              if (m_g[l] == 4) begin
                m_g[l] = 0; m_e[l]--;
                if (m_e[l] == 0) m_st[l] = 2;
              end
            end
          end
        end
      end
    end
    m_sync = 1'b1;
    for (int l = 0; l < LANES; l++) if (m_st[l] == 0) m_sync = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_oct(input int l, input int n, input logic [7:0] d, input logic k, input logic e);
    td[(l*OCTETS+n)*8 +: 8] = d;
    tk[l*OCTETS+n] = k;
    te[l*OCTETS+n] = e;
  endtask

  task automatic set_kind(input int l, input int n, input int kind);
    case (kind)
      OK_K:    set_oct(l, n, 8'hBC, 1'b1, 1'b0);
      OK_D:    set_oct(l, n, 8'h00, 1'b0, 1'b0);
      default: set_oct(l, n, 8'hBC, 1'b1, 1'b1);
    endcase
  endtask

  task automatic set_lane(input int l, input int k0, input int k1);
    set_kind(l, 0, k0);
    set_kind(l, 1, k1);
  endtask

  task automatic fill_all(input logic [7:0] d, input logic k, input logic e);
    for (int j = 0; j < NOCT; j++) begin
      td[j*8 +: 8] = d; tk[j] = k; te[j] = e;
    end
  endtask

  // Apply one word, advance the model, compare every output after the edge.
  task automatic step(input logic v, input logic r);
    logic [LANES*2-1:0] exp_ls;
    @(negedge clk);
    data_in = td; is_k = tk; code_err = te; valid_in = v; rst = r;
    model_step(v, r);
    for (int l = 0; l < LANES; l++) exp_ls[l*2 +: 2] = 2'(m_st[l]);
    @(posedge clk);
    #1;
    check("kcls_out", 64'(kcls_out), 64'(m_kcls));
    check("valid_out", 64'(valid_out), 64'(m_vout));
    check("lane_state", 64'(lane_state), 64'(exp_ls));
    check("sync_n", 64'(sync_n), 64'(m_sync));
`ifdef JESD_CTRL_CHAR_STATS_EN
    for (int l = 0; l < LANES; l++)
      check("stat_af_cnt", 64'(stat_af_cnt[l*16 +: 16]), 64'(m_af[l]));
`endif
  endtask

  task automatic do_reset();
    fill_all(8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1);
  endtask

  // ---------------- classification table ----------------
  typedef struct {
    logic [7:0] d;
    logic       k;
    logic [2:0] cls;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [NOCT*3-1:0] exp_k;
    int rr;

    vecs[0]  = '{8'hBC, 1'b1, 3'd1};
    vecs[1]  = '{8'h1C, 1'b1, 3'd2};
    vecs[2]  = '{8'h7C, 1'b1, 3'd3};
    vecs[3]  = '{8'h9C, 1'b1, 3'd4};
    vecs[4]  = '{8'hFC, 1'b1, 3'd5};
    vecs[5]  = '{8'hF7, 1'b1, 3'd6};
    vecs[6]  = '{8'h5C, 1'b1, 3'd6};
    vecs[7]  = '{8'hFE, 1'b1, 3'd6};
    vecs[8]  = '{8'h00, 1'b1, 3'd7};
    vecs[9]  = '{8'hBD, 1'b1, 3'd7};
    vecs[10] = '{8'hBC, 1'b0, 3'd0};
    vecs[11] = '{8'h7C, 1'b0, 3'd0};

    rst = 1'b1; valid_in = 1'b0; data_in = '0; is_k = '0; code_err = '0;
    td = '0; tk = '0; te = '0;
    for (int l = 0; l < LANES; l++) begin
      m_st[l] = 0; m_k[l] = 0; m_e[l] = 0; m_g[l] = 0; m_af[l] = 0;
    end

    // reset state
    do_reset();
    do_reset();
    check("reset_lane_state", 64'(lane_state), 64'd0);
    check("reset_sync_n", 64'(sync_n), 64'd0);
    check("reset_kcls", 64'(kcls_out), 64'd0);

    // two all-K words reach DATA on the second edge
    fill_all(8'hBC, 1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("allk_w1_sync", 64'(sync_n), 64'd0);
    step(1'b1, 1'b0);
    check("allk_w2_state", 64'(lane_state), 64'h0A);
    check("allk_w2_sync", 64'(sync_n), 64'd1);

    // classification table with valid_in=0: FSMs frozen at K count 2
    do_reset();
    fill_all(8'hBC, 1'b1, 1'b0);
    step(1'b1, 1'b0);
    foreach (vecs[i]) begin
      fill_all(vecs[i].d, vecs[i].k, 1'b0);
      step(1'b0, 1'b0);
      exp_k = {NOCT{vecs[i].cls}};
      exp_q.push_back(64'(exp_k));
      check("table_kcls", 64'(kcls_out), exp_q.pop_front());
      check("table_frozen_state", 64'(lane_state), 64'd0);
      check("table_valid_out", 64'(valid_out), 64'd0);
    end
    fill_all(8'hBC, 1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("unfreeze_state", 64'(lane_state), 64'h0A);

    // K count restarts on a data octet
    do_reset();
    set_lane(1, OK_K, OK_K);
    set_lane(0, OK_K, OK_K); step(1'b1, 1'b0);
    set_lane(0, OK_K, OK_D); step(1'b1, 1'b0);
    set_lane(0, OK_K, OK_K); step(1'b1, 1'b0);
    check("restart_l0_init", 64'(lane_state[1:0]), 64'd0);
    check("restart_l1_data", 64'(lane_state[3:2]), 64'd2);
    check("restart_sync_low", 64'(sync_n), 64'd0);
    step(1'b1, 1'b0);
    check("restart_l0_data", 64'(lane_state[1:0]), 64'd2);
    check("restart_sync_high", 64'(sync_n), 64'd1);

    // mid-word transition: 4th K at octet 0, error at octet 1
    do_reset();
    set_lane(1, OK_K, OK_K);
    set_lane(0, OK_D, OK_K); step(1'b1, 1'b0);
    set_lane(0, OK_K, OK_K); step(1'b1, 1'b0);
    set_lane(0, OK_K, OK_E); step(1'b1, 1'b0);
    check("midword_check", 64'(lane_state[1:0]), 64'd1);
    check("midword_sync", 64'(sync_n), 64'd1);

    // three errors with fewer than four goods between -> INIT
    set_lane(0, OK_D, OK_D); step(1'b1, 1'b0);
    set_lane(0, OK_E, OK_D); step(1'b1, 1'b0);
    check("errs_still_check", 64'(lane_state[1:0]), 64'd1);
    set_lane(0, OK_D, OK_E); step(1'b1, 1'b0);
    check("errs_to_init", 64'(lane_state[1:0]), 64'd0);
    check("errs_sync_low", 64'(sync_n), 64'd0);

    // back to DATA, one error then four goods -> DATA
    set_lane(0, OK_K, OK_K); step(1'b1, 1'b0); step(1'b1, 1'b0);
    check("rejoin_data", 64'(lane_state[1:0]), 64'd2);
    set_lane(0, OK_E, OK_D); step(1'b1, 1'b0);
    set_lane(0, OK_D, OK_D); step(1'b1, 1'b0);
    check("recover_in_check", 64'(lane_state[1:0]), 64'd1);
    step(1'b1, 1'b0);
    check("recover_data", 64'(lane_state[1:0]), 64'd2);

    // reset in CHECK with err_cnt=2, then K_THRESH fresh Ks
    set_lane(0, OK_E, OK_E); step(1'b1, 1'b0);
    check("chk2_state", 64'(lane_state[1:0]), 64'd1);
    set_lane(0, OK_K, OK_K); step(1'b1, 1'b1);
    check("rst_over_valid_state", 64'(lane_state), 64'd0);
    check("rst_over_valid_vout", 64'(valid_out), 64'd0);
    step(1'b1, 1'b0);
    check("post_rst_2k_init", 64'(lane_state[1:0]), 64'd0);
    step(1'b1, 1'b1);  // reset with a partial K count pending
    step(1'b1, 1'b0);
    check("no_residual_k", 64'(lane_state[1:0]), 64'd0);
    step(1'b1, 1'b0);
    check("post_rst_4k_data", 64'(lane_state[1:0]), 64'd2);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int j = 0; j < NOCT; j++) begin
        rr = $urandom_range(0, 99);
        if (rr < 60)      begin td[j*8 +: 8] = 8'hBC; tk[j] = 1'b1; te[j] = 1'b0; end
        else if (rr < 70) begin td[j*8 +: 8] = 8'($urandom); tk[j] = 1'b0; te[j] = 1'b0; end
        else if (rr < 80) begin td[j*8 +: 8] = 8'hBC; tk[j] = 1'b1; te[j] = 1'b1; end
        else if (rr < 88) begin td[j*8 +: 8] = 8'($urandom); tk[j] = 1'b1; te[j] = 1'b0; end
        else if (rr < 95) begin td[j*8 +: 8] = 8'h7C; tk[j] = 1'b1; te[j] = 1'b0; end
        else              begin td[j*8 +: 8] = 8'hFC; tk[j] = 1'b1; te[j] = 1'b0; end
      end
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0));
    end

`ifdef JESD_CTRL_CHAR_STATS_EN
    // /A/ stream in DATA saturates the counter
    do_reset();
    fill_all(8'hBC, 1'b1, 1'b0);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    fill_all(8'h7C, 1'b1, 1'b0);
    for (int c = 0; c < 35000; c++) step(1'b1, 1'b0);
    check("af_saturate_l0", 64'(stat_af_cnt[15:0]), 64'hFFFF);
    check("af_saturate_l1", 64'(stat_af_cnt[31:16]), 64'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
